// File: rtl/game_board_if.sv
// Move/board bus between the move sources and the tic-tac-toe board controller.
// The master side submits moves; the slave side (the board) reports game state.
interface game_board_if;
  logic [3:0]  update_loc;
  logic [1:0]  update_val;
  logic        submit;
  logic        reset;
  logic [17:0] board_state;
  logic        turn;
  logic [3:0]  move_cnt;
  logic        game_over;
  logic [1:0]  winner;
  logic        move_err;

  modport master (
    output update_loc, update_val, submit, reset,
    input  board_state, turn, move_cnt, game_over, winner, move_err
  );

  modport slave (
    input  update_loc, update_val, submit, reset,
    output board_state, turn, move_cnt, game_over, winner, move_err
  );
endinterface

// File: rtl/game_board.sv
// Tic-tac-toe board controller: synchronizes move strobes, validates and applies
// moves, then scores the board for win/draw and hands the turn to the other side.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  S_PLAY  | waiting for a submit edge; valid move is written, bad one flagged
//  S_CHECK | one cycle scoring the freshly written board
//  S_DONE  | game decided; board frozen until a game reset
module game_board #(
  parameter logic FIRST_TURN  = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  game_board_if.slave   bif
);

  localparam logic [1:0] S_PLAY  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] MARK_X    = 2'b01;
  localparam logic [1:0] MARK_O    = 2'b10;
  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_DRAW  = 2'b11;
  localparam logic [3:0] CNT_FULL  = 4'd9;

  logic [1:0]             state;
  logic [17:0]            board;
  logic                   turn;
  logic [3:0]             move_cnt;
  logic                   game_over;
  logic [1:0]             winner;
  logic                   move_err;

  logic [SYNC_STAGES-1:0] sub_sync;
  logic [SYNC_STAGES-1:0] rst_sync;
  logic                   sub_d;
  logic                   sub_in;
  logic                   rst_in;
  logic                   sub_s;
  logic                   rst_s;
  logic                   sub_edge;

  logic [1:0]             cur_cell;
  logic                   loc_ok;
  logic [1:0]             turn_mark;
  logic                   move_ok;
  logic [17:0]            board_wr;
  logic                   x_win;
  logic                   o_win;

  // Undriven or unknown strobes from the movers must never look like a request.
  assign sub_in = (bif.submit === 1'b1);
  assign rst_in = (bif.reset === 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_sync <= '0;
      rst_sync <= '0;
      sub_d    <= 1'b0;
    end else begin
      sub_sync <= {sub_sync[SYNC_STAGES-2:0], sub_in};
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], rst_in};
      sub_d    <= sub_s;
    end
  end

  assign sub_s    = sub_sync[SYNC_STAGES-1];
  assign rst_s    = rst_sync[SYNC_STAGES-1];
  assign sub_edge = sub_s & ~sub_d;

  always_comb begin
    cur_cell = 2'b00;
    loc_ok   = 1'b0;
    board_wr = board;
    for (int i = 0; i < 9; i++) begin
      if (bif.update_loc == 4'(i)) begin
        cur_cell           = board[2*i +: 2];
        loc_ok             = 1'b1;
        board_wr[2*i +: 2] = bif.update_val;
      end
    end
  end

  assign turn_mark = turn ? MARK_O : MARK_X;
  assign move_ok   = loc_ok && (cur_cell == 2'b00) && (bif.update_val == turn_mark);

  function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] hit;
    for (int i = 0; i < 9; i++) hit[i] = (b[2*i +: 2] == m);
    return (hit[0] & hit[1] & hit[2]) | (hit[3] & hit[4] & hit[5]) |
           (hit[6] & hit[7] & hit[8]) | (hit[0] & hit[3] & hit[6]) |
           (hit[1] & hit[4] & hit[7]) | (hit[2] & hit[5] & hit[8]) |
           (hit[0] & hit[4] & hit[8]) | (hit[2] & hit[4] & hit[6]);
  endfunction

  assign x_win = has_line(board, MARK_X);
  assign o_win = has_line(board, MARK_O);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PLAY;
      board     <= '0;
      turn      <= FIRST_TURN;
      move_cnt  <= '0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
      move_err  <= 1'b0;
    end else if (rst_s) begin
      // Game restart swallows any coincident submit edge without flagging it.
      state     <= S_PLAY;
      board     <= '0;
      turn      <= FIRST_TURN;
      move_cnt  <= '0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
      move_err  <= 1'b0;
    end else begin
      move_err <= 1'b0;
      case (state)
        S_PLAY: begin
          if (sub_edge) begin
            if (move_ok) begin
              board    <= board_wr;
              move_cnt <= (move_cnt == CNT_FULL) ? CNT_FULL : move_cnt + 4'd1;
              state    <= S_CHECK;
            end else begin
              move_err <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (sub_edge) move_err <= 1'b1;
          if (x_win) begin
            winner    <= MARK_X;
            game_over <= 1'b1;
            state     <= S_DONE;
          end else if (o_win) begin
            winner    <= MARK_O;
            game_over <= 1'b1;
            state     <= S_DONE;
          end else if (move_cnt == CNT_FULL) begin
            winner    <= WIN_DRAW;
            game_over <= 1'b1;
            state     <= S_DONE;
          end else begin
            turn  <= ~turn;
            state <= S_PLAY;
          end
        end
        S_DONE: begin
          if (sub_edge) move_err <= 1'b1;
        end
        default: state <= S_PLAY;
      endcase
    end
  end

  assign bif.board_state = board;
  assign bif.turn        = turn;
  assign bif.move_cnt    = move_cnt;
  assign bif.game_over   = game_over;
  assign bif.winner      = winner;
  assign bif.move_err    = move_err;

endmodule
